// File: rtl/axis_traffic_gen_if.sv
// AXI-Stream bundle between a traffic generator (master) and a NoC input slot (slave).
interface axis_traffic_gen_if #(
   parameter int unsigned TID_WIDTH   = 2,
   parameter int unsigned TDEST_WIDTH = 4,
   parameter int unsigned TDATA_WIDTH = 512
) ();

   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tlast;
   logic [TID_WIDTH-1:0]   tid;
   logic [TDEST_WIDTH-1:0] tdest;

   modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
   modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);

endinterface

// File: rtl/axis_traffic_gen.sv
// Per-node AXI-Stream packet source for NoC bring-up and throughput tests.
// Emits cfg_num_pkts packets with a rotating destination and a self-describing
// payload (beat index, packet sequence, node id).
// Optional inter-packet gap: define TRAFFIC_GEN_GAP_EN.
module axis_traffic_gen #(
   parameter int unsigned TID_WIDTH   = 2,
   parameter int unsigned TDEST_WIDTH = 4,
   parameter int unsigned TDATA_WIDTH = 512,
   parameter int unsigned NUM_NODES   = 16,
   parameter int unsigned NODE_ID     = 0,
   parameter int unsigned MAX_PKT_LEN = 16,
   parameter int unsigned SKIP_SELF   = 1
) (
   input  logic                              clk_usr,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [15:0]                       cfg_num_pkts,
   input  logic [$clog2(MAX_PKT_LEN):0]      cfg_pkt_len,
   input  logic [TDEST_WIDTH-1:0]            cfg_dest_start,
   input  logic [7:0]                        cfg_gap,
   axis_traffic_gen_if.master                axis,
   output logic                              busy,
   output logic                              done,
   output logic [15:0]                       pkts_sent
);

   localparam int unsigned LEN_W = $clog2(MAX_PKT_LEN) + 1;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
`ifdef TRAFFIC_GEN_GAP_EN
      GAP,
`endif
      FIN
   } state_t;

   state_t                 state_q, state_d;
   logic [15:0]            num_pkts_q, num_pkts_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic [LEN_W-1:0]       beat_q, beat_d;
   logic [15:0]            pkts_sent_q, pkts_sent_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;
   logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [TID_WIDTH-1:0]   tid_q, tid_d;
   logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

`ifdef TRAFFIC_GEN_GAP_EN
   logic [7:0]             gap_q, gap_d;
   logic [7:0]             gap_cnt_q, gap_cnt_d;
`else
   logic                   gap_unused_c;
   assign gap_unused_c = ^cfg_gap;
`endif

   logic [LEN_W-1:0]       start_len_c;
   logic                   load_c;
   logic [LEN_W-1:0]       load_beat_c;
   logic [15:0]            load_seq_c;
   logic [LEN_W-1:0]       load_len_c;
   logic [15:0]            pkts_inc_c;
   logic [LEN_W-1:0]       beat_inc_c;

   // +1 modulo NUM_NODES
   function automatic logic [TDEST_WIDTH-1:0] wrap_inc(input logic [TDEST_WIDTH-1:0] d);
      if (32'(d) >= NUM_NODES - 1) return '0;
      return TDEST_WIDTH'(32'(d) + 32'd1);
   endfunction

   // step past our own node when self-traffic is disabled
   function automatic logic [TDEST_WIDTH-1:0] skip_self(input logic [TDEST_WIDTH-1:0] d);
      if (SKIP_SELF != 0 && 32'(d) == NODE_ID) return wrap_inc(d);
      return d;
   endfunction

   function automatic logic [TDATA_WIDTH-1:0] payload(input logic [LEN_W-1:0] beat,
                                                      input logic [15:0] seq);
      logic [TDATA_WIDTH-1:0] p;
      p        = '0;
      p[15:0]  = 16'(beat);
      p[31:16] = seq;
      p[47:32] = 16'(NODE_ID);
      return p;
   endfunction

   // zero-length becomes one beat, oversize clamps to MAX_PKT_LEN
   always_comb begin
      if (cfg_pkt_len == '0)                   start_len_c = LEN_W'(1);
      else if (32'(cfg_pkt_len) > MAX_PKT_LEN) start_len_c = LEN_W'(MAX_PKT_LEN);
      else                                     start_len_c = cfg_pkt_len;
   end

   assign pkts_inc_c = 16'(pkts_sent_q + 16'd1);
   assign beat_inc_c = LEN_W'(beat_q + LEN_W'(1));

   // next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      num_pkts_d  = num_pkts_q;
      len_d       = len_q;
      beat_d      = beat_q;
      pkts_sent_d = pkts_sent_q;
      tvalid_d    = tvalid_q;
      tlast_d     = tlast_q;
      tdata_d     = tdata_q;
      tid_d       = tid_q;
      tdest_d     = tdest_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef TRAFFIC_GEN_GAP_EN
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
`endif
      load_c      = 1'b0;
      load_beat_c = '0;
      load_seq_c  = pkts_sent_q;
      load_len_c  = len_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               num_pkts_d  = cfg_num_pkts;
               len_d       = start_len_c;
               beat_d      = '0;
               pkts_sent_d = '0;
               busy_d      = 1'b1;
`ifdef TRAFFIC_GEN_GAP_EN
               gap_d       = cfg_gap;
`endif
               if (cfg_num_pkts == '0) begin
                  state_d = FIN;
               end else begin
                  state_d    = SEND;
                  tdest_d    = skip_self(TDEST_WIDTH'(32'(cfg_dest_start) % NUM_NODES));
                  load_c     = 1'b1;
                  load_seq_c = '0;
                  load_len_c = start_len_c;
               end
            end
         end
         SEND: begin
            if (tvalid_q && axis.tready) begin
               if (tlast_q) begin
                  pkts_sent_d = pkts_inc_c;
                  beat_d      = '0;
                  if (pkts_inc_c == num_pkts_q) begin
                     state_d  = FIN;
                     tvalid_d = 1'b0;
                     tlast_d  = 1'b0;
                  end else begin
                     tdest_d = skip_self(wrap_inc(tdest_q));
`ifdef TRAFFIC_GEN_GAP_EN
                     if (gap_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                     end else begin
                        load_c     = 1'b1;
                        load_seq_c = pkts_inc_c;
                     end
`else
                     load_c     = 1'b1;
                     load_seq_c = pkts_inc_c;
`endif
                  end
               end else begin
                  beat_d      = beat_inc_c;
                  load_c      = 1'b1;
                  load_beat_c = beat_inc_c;
               end
            end
         end
`ifdef TRAFFIC_GEN_GAP_EN
         GAP: begin
            if (gap_cnt_q <= 8'd1) begin
               state_d = SEND;
               load_c  = 1'b1;
            end else begin
               gap_cnt_d = 8'(gap_cnt_q - 8'd1);
            end
         end
`endif
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load_c) begin
         tvalid_d = 1'b1;
         tdata_d  = payload(load_beat_c, load_seq_c);
         tid_d    = TID_WIDTH'(load_seq_c);
         tlast_d  = (load_beat_c == LEN_W'(load_len_c - LEN_W'(1)));
      end
   end

   // state and output registers
   always_ff @(posedge clk_usr or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         num_pkts_q  <= '0;
         len_q       <= LEN_W'(1);
         beat_q      <= '0;
         pkts_sent_q <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tdata_q     <= '0;
         tid_q       <= '0;
         tdest_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef TRAFFIC_GEN_GAP_EN
         gap_q       <= '0;
         gap_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         num_pkts_q  <= num_pkts_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         pkts_sent_q <= pkts_sent_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
         tdata_q     <= tdata_d;
         tid_q       <= tid_d;
         tdest_q     <= tdest_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef TRAFFIC_GEN_GAP_EN
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
`endif
      end
   end

   assign axis.tvalid = tvalid_q;
   assign axis.tlast  = tlast_q;
   assign axis.tdata  = tdata_q;
   assign axis.tid    = tid_q;
   assign axis.tdest  = tdest_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pkts_sent   = pkts_sent_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed self-checking bench for axis_traffic_gen (NODE_ID=0, SKIP_SELF=1).
module tb_axis_traffic_gen;

   localparam int unsigned TID_W   = 2;
   localparam int unsigned TDEST_W = 4;
   localparam int unsigned TDATA_W = 512;
   localparam int unsigned MAX_LEN = 16;
   localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;

   logic               clk_usr = 1'b0;
   logic               rst_n   = 1'b0;
   logic               start   = 1'b0;
   logic [15:0]        cfg_num_pkts   = '0;
   logic [LEN_W-1:0]   cfg_pkt_len    = '0;
   logic [TDEST_W-1:0] cfg_dest_start = '0;
   logic [7:0]         cfg_gap        = '0;
   logic               busy;
   logic               done;
   logic [15:0]        pkts_sent;

   int checks = 0;
   int errors = 0;
   int exp_dest [8];

   always #5 clk_usr = ~clk_usr;

   axis_traffic_gen_if #(.TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W), .TDATA_WIDTH(TDATA_W)) axis ();

   axis_traffic_gen #(
      .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W), .TDATA_WIDTH(TDATA_W),
      .NUM_NODES(16), .NODE_ID(0), .MAX_PKT_LEN(MAX_LEN), .SKIP_SELF(1)
   ) dut (
      .clk_usr(clk_usr), .rst_n(rst_n), .start(start),
      .cfg_num_pkts(cfg_num_pkts), .cfg_pkt_len(cfg_pkt_len),
      .cfg_dest_start(cfg_dest_start), .cfg_gap(cfg_gap),
      .axis(axis), .busy(busy), .done(done), .pkts_sent(pkts_sent)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_usr);
      #1;
   endtask

   task automatic set_cfg(input int n, input int len, input int dest, input int gap);
      cfg_num_pkts   = 16'(n);
      cfg_pkt_len    = LEN_W'(len);
      cfg_dest_start = TDEST_W'(dest);
      cfg_gap        = 8'(gap);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // walk a run beat by beat, checking every presented beat against the expected stream
   task automatic run_stream(input int npk, input int len, input bit stall, input bit poke);
      int beat = 0;
      int pkt  = 0;
      int cyc  = 0;
      while (pkt < npk && cyc < 1000) begin
         chk("tvalid_run", {63'd0, axis.tvalid}, 64'd1);
         if (axis.tvalid !== 1'b1) break;
         chk("tdata_lo", {16'd0, axis.tdata[47:0]}, {16'd0, 16'h0000, 16'(pkt), 16'(beat)});
         chk("tdata_hi", {63'd0, |axis.tdata[TDATA_W-1:48]}, 64'd0);
         chk("tid", 64'(axis.tid), 64'(pkt % 4));
         chk("tdest", 64'(axis.tdest), 64'(exp_dest[pkt]));
         chk("tlast", {63'd0, axis.tlast}, {63'd0, beat == len - 1});
         chk("busy_run", {63'd0, busy}, 64'd1);
         chk("done_run", {63'd0, done}, 64'd0);
         axis.tready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (poke && cyc == 2) begin
            start = 1'b1;
            set_cfg(5, 1, 9, 0);
         end else begin
            start = 1'b0;
         end
         if (axis.tready) begin
            if (beat == len - 1) begin
               beat = 0;
               pkt++;
            end else begin
               beat++;
            end
         end
         cyc++;
         step();
      end
      start       = 1'b0;
      axis.tready = 1'b1;
      chk("run_complete", 64'(pkt), 64'(npk));
   endtask

   // called right after the final tlast transfer
   task automatic finish_check(input int n);
      chk("fin_tvalid", {63'd0, axis.tvalid}, 64'd0);
      chk("fin_busy", {63'd0, busy}, 64'd1);
      chk("fin_done_early", {63'd0, done}, 64'd0);
      chk("fin_pkts", 64'(pkts_sent), 64'(n));
      step();
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("busy_clear", {63'd0, busy}, 64'd0);
      chk("idle_tvalid", {63'd0, axis.tvalid}, 64'd0);
      chk("pkts_hold", 64'(pkts_sent), 64'(n));
      step();
      chk("done_once", {63'd0, done}, 64'd0);
      chk("pkts_hold2", 64'(pkts_sent), 64'(n));
   endtask

   initial begin
      int pat [5];
      axis.tready = 1'b1;
      #12;
      chk("rst_tvalid", {63'd0, axis.tvalid}, 64'd0);
      chk("rst_tlast", {63'd0, axis.tlast}, 64'd0);
      chk("rst_tdata", {63'd0, |axis.tdata}, 64'd0);
      chk("rst_tid", 64'(axis.tid), 64'd0);
      chk("rst_tdest", 64'(axis.tdest), 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_pkts", 64'(pkts_sent), 64'd0);
      @(negedge clk_usr);
      rst_n = 1'b1;
      step();

      // three 2-beat packets, destination 0 skipped
      set_cfg(3, 2, 15, 0);
      exp_dest[0] = 15; exp_dest[1] = 1; exp_dest[2] = 2;
      pulse_start();
      run_stream(3, 2, 1'b0, 1'b0);
      finish_check(3);

      // 4-beat packets under tready stalls
      set_cfg(2, 4, 3, 0);
      exp_dest[0] = 3; exp_dest[1] = 4;
      pulse_start();
      run_stream(2, 4, 1'b1, 1'b0);
      finish_check(2);

      // empty run
      set_cfg(0, 2, 0, 0);
      pulse_start();
      chk("z_busy", {63'd0, busy}, 64'd1);
      chk("z_tvalid", {63'd0, axis.tvalid}, 64'd0);
      chk("z_done_early", {63'd0, done}, 64'd0);
      chk("z_pkts", 64'(pkts_sent), 64'd0);
      step();
      chk("z_done", {63'd0, done}, 64'd1);
      chk("z_busy_clr", {63'd0, busy}, 64'd0);
      chk("z_tvalid2", {63'd0, axis.tvalid}, 64'd0);
      step();
      chk("z_done_once", {63'd0, done}, 64'd0);

      // zero length becomes 1 beat
      set_cfg(2, 0, 5, 0);
      exp_dest[0] = 5; exp_dest[1] = 6;
      pulse_start();
      run_stream(2, 1, 1'b0, 1'b0);
      finish_check(2);

      // oversize length clamps; start dest 0 skips to 1
      set_cfg(1, MAX_LEN + 5, 0, 0);
      exp_dest[0] = 1;
      pulse_start();
      run_stream(1, MAX_LEN, 1'b0, 1'b0);
      finish_check(1);

      // second start mid-run is ignored
      set_cfg(2, 3, 7, 0);
      exp_dest[0] = 7; exp_dest[1] = 8;
      pulse_start();
      run_stream(2, 3, 1'b0, 1'b1);
      finish_check(2);

      // asynchronous reset mid-packet
      set_cfg(3, 4, 2, 0);
      pulse_start();
      step();
      step();
      chk("pre_rst_tvalid", {63'd0, axis.tvalid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_tvalid", {63'd0, axis.tvalid}, 64'd0);
      chk("arst_tlast", {63'd0, axis.tlast}, 64'd0);
      chk("arst_tdata", {63'd0, |axis.tdata}, 64'd0);
      chk("arst_tid", 64'(axis.tid), 64'd0);
      chk("arst_tdest", 64'(axis.tdest), 64'd0);
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_pkts", 64'(pkts_sent), 64'd0);
      @(negedge clk_usr);
      rst_n = 1'b1;
      step();
      set_cfg(1, 1, 2, 0);
      exp_dest[0] = 2;
      pulse_start();
      run_stream(1, 1, 1'b0, 1'b0);
      finish_check(1);

`ifdef TRAFFIC_GEN_GAP_EN
      // three idle cycles between single-beat packets
      set_cfg(2, 1, 0, 3);
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 0; pat[4] = 1;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         chk("gap_tvalid", {63'd0, axis.tvalid}, 64'(pat[i]));
         step();
      end
      finish_check(2);
`else
      pat[0] = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
- Per-node AXI-Stream packet source on the clk_usr side, driving one axis_in_* slot of the mesh NoC wrapper.
- Emits a programmed number of packets with a rotating destination sequence and self-describing payload, for bring-up and throughput tests.
- Paired with a checker at axis_out; every beat carries enough information to verify source, sequence and beat order.

Parameters:
- TID_WIDTH, 2, width of axis_tid.
- TDEST_WIDTH, 4, width of axis_tdest.
- TDATA_WIDTH, 512, beat width; must be >= 48.
- NUM_NODES, 16, destination wrap modulus; must be <= 2**TDEST_WIDTH.
- NODE_ID, 0, this node's index, placed in the payload.
- MAX_PKT_LEN, 16, maximum beats per packet.
- SKIP_SELF, 1, when 1 the destination sequence never equals NODE_ID.

Ports:
- clk_usr  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a run.
- cfg_num_pkts  in  16  packets per run.
- cfg_pkt_len  in  $clog2(MAX_PKT_LEN)+1  beats per packet.
- cfg_dest_start  in  TDEST_WIDTH  first destination.
- cfg_gap  in  8  idle cycles between packets; used only with the optional feature.
- axis_tvalid  out  1  stream valid.
- axis_tready  in  1  stream ready.
- axis_tdata  out  TDATA_WIDTH  payload.
- axis_tlast  out  1  last beat of packet.
- axis_tid  out  TID_WIDTH  packet sequence LSBs.
- axis_tdest  out  TDEST_WIDTH  destination node.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pkts_sent  out  16  packets completed in the current/last run.

Behaviour:
- Single clock domain clk_usr. Reset: asynchronous on rst_n low; all state returns to IDLE.
- Reset values: axis_tvalid=0, axis_tlast=0, axis_tdata=0, axis_tid=0, axis_tdest=0, busy=0, done=0, pkts_sent=0.
- Reset mid-packet abandons the packet immediately; no tlast is produced.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 latches all cfg_*; pkts_sent clears to 0; busy=1 next cycle.
  - If cfg_num_pkts==0, go to FIN. Otherwise go to SEND with axis_tvalid=1 on the next cycle (one-cycle start-to-valid latency).
- Config rules:
  - cfg_pkt_len of 0 is treated as 1; values above MAX_PKT_LEN clamp to MAX_PKT_LEN.
  - start while busy=1 is ignored; latched config is unaffected.
- SEND handshake:
  - A beat transfers when axis_tvalid && axis_tready.
  - axis_tvalid, axis_tdata, axis_tlast, axis_tid and axis_tdest stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a transfer.
- Beat payload:
  - tdata[15:0] = beat index (0-based).
  - tdata[31:16] = packet sequence number (0-based within the run).
  - tdata[47:32] = NODE_ID.
  - All higher bits = 0.
- Per-packet fields:
  - axis_tid = packet sequence[TID_WIDTH-1:0].
  - axis_tlast=1 only on beat index len-1.
- Back-to-back transfers (tready held at 1) sustain one beat per cycle, including across packet boundaries, when the optional feature is absent or cfg_gap==0.
- On the tlast transfer:
  - pkts_sent increments.
  - If pkts_sent reaches cfg_num_pkts, go to FIN. Otherwise advance the destination and continue in SEND, or go to GAP (optional feature).
- Destination sequence:
  - The first packet uses cfg_dest_start mod NUM_NODES.
  - Each next destination is +1, wrapping from NUM_NODES-1 to 0.
  - With SKIP_SELF=1, a value equal to NODE_ID is skipped by one further increment. This applies to the first packet as well.
  - Sequence number wraps at 2**16.
- FIN: one cycle with done=1 and busy=0 thereafter; return to IDLE. pkts_sent holds until the next start.

Optional Feature:
- Macro: TRAFFIC_GEN_GAP_EN.
- When defined: after each non-final packet the FSM spends exactly cfg_gap cycles in GAP with axis_tvalid=0, then returns to SEND. cfg_gap==0 skips GAP.
- When undefined: the GAP state and its counter are not compiled; cfg_gap is ignored; packets are always back-to-back.

Test Plan:
- NODE_ID=0, SKIP_SELF=1, start with num_pkts=3, pkt_len=2, dest_start=15, tready=1 -> 6 beats on consecutive cycles.
  - tdest sequence 15,1,2 (0 skipped); tid 0,1,2.
  - tlast on beats 1,3,5; done pulses once; pkts_sent=3.
- pkt_len=4, tready toggling 1,0,0,1,... -> all outputs stable across stalls.
  - Beat indices 0..3 appear exactly once, in order.
- num_pkts=0 -> no tvalid; done pulses 2 cycles after start; pkts_sent=0.
- pkt_len=0 and pkt_len=MAX_PKT_LEN+5 -> packets of 1 and MAX_PKT_LEN beats respectively.
- Second start pulse mid-run -> ignored; run completes with the original config.
- rst_n low mid-packet -> all outputs 0 asynchronously.
  - After release, a fresh start produces packet sequence 0.
- With TRAFFIC_GEN_GAP_EN, cfg_gap=3, num_pkts=2, pkt_len=1 -> tvalid pattern 1,0,0,0,1.
